// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID register, with stall, redirect, misaligned-target fault and fetch counting.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_inst,
   output logic [31:0] pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_cnt
);

   typedef enum logic {RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         inst_q     <= NOP_INST;
         pc4_q      <= 32'd0;
         valid_q    <= 1'b0;
         fault_pc_q <= 32'd0;
         cnt_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
         fault_pc_q <= fault_pc_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      fault_pc_d = fault_pc_q;
      cnt_d      = cnt_q;
      case (state_q)
         RUN: begin
            // Redirect outranks stall; a misaligned target freezes the stage for good.
            if (br_taken && (br_target[1:0] != 2'b00)) begin
               state_d    = FAULT;
               fault_pc_d = br_target;
               inst_d     = NOP_INST;
               valid_d    = 1'b0;
            end else if (br_taken) begin
               pc_d    = br_target;
               inst_d  = NOP_INST;
               valid_d = 1'b0;
            end else if (!stall) begin
               pc_d    = pc_plus4;
               inst_d  = rom_inst;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
               cnt_d   = cnt_q + 32'd1;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: state_d = RUN;
      endcase
   end

   assign rom_addr    = pc_q;
   assign pc          = pc_q;
   assign if_id_inst  = inst_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign fault       = (state_q == FAULT);
   assign fault_pc    = fault_pc_q;
   assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 64-word combinational ROM model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic [31:0] pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_cnt;

   logic [31:0] rom [64];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign rom_inst = rom[rom_addr[7:2]];

   fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
      .br_target(br_target), .rom_addr(rom_addr), .rom_inst(rom_inst),
      .pc(pc), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid), .fault(fault), .fault_pc(fault_pc),
      .fetch_cnt(fetch_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      repeat (3) step();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      n_cmp++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL reset_rom_addr: got %h want %h", rom_addr, 32'h0); end
      n_cmp++; if (if_id_inst !== NOP) begin n_err++; $display("FAIL reset_inst: got %h want %h", if_id_inst, NOP); end
      n_cmp++; if (if_id_pc4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %h want %h", if_id_pc4, 32'h0); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
      n_cmp++; if (fault_pc !== 32'h0) begin n_err++; $display("FAIL reset_fault_pc: got %h want 0", fault_pc); end
      n_cmp++; if (fetch_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      step();
      n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL seq1_pc: got %h want %h", pc, 32'h4); end
      n_cmp++; if (if_id_inst !== 32'h3c001000) begin n_err++; $display("FAIL seq1_inst: got %h want %h", if_id_inst, 32'h3c001000); end
      n_cmp++; if (if_id_pc4 !== 32'h4) begin n_err++; $display("FAIL seq1_pc4: got %h want %h", if_id_pc4, 32'h4); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq1_valid: got %b want 1", if_id_valid); end
      step();
      n_cmp++; if (if_id_inst !== 32'h14003c01) begin n_err++; $display("FAIL seq2_inst: got %h want %h", if_id_inst, 32'h14003c01); end
      n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL seq2_pc: got %h want %h", pc, 32'h8); end
      n_cmp++; if (fetch_cnt !== 32'd2) begin n_err++; $display("FAIL seq2_cnt: got %0d want 2", fetch_cnt); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      step(); step();
      n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL stall_pc: got %h want %h", pc, 32'h8); end
      n_cmp++; if (if_id_inst !== 32'h14003c01) begin n_err++; $display("FAIL stall_inst: got %h want %h", if_id_inst, 32'h14003c01); end
      n_cmp++; if (fetch_cnt !== 32'd2) begin n_err++; $display("FAIL stall_cnt: got %0d want 2", fetch_cnt); end
      stall = 1'b0;
      step();
      n_cmp++; if (if_id_inst !== 32'h14005002) begin n_err++; $display("FAIL unstall_inst: got %h want %h", if_id_inst, 32'h14005002); end
      n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL unstall_pc: got %h want %h", pc, 32'hC); end
      n_cmp++; if (fetch_cnt !== 32'd3) begin n_err++; $display("FAIL unstall_cnt: got %0d want 3", fetch_cnt); end
   endtask

   task automatic test_branch();
      br_taken = 1'b1; br_target = 32'h14;
      step();
      br_taken = 1'b0; br_target = 'x;
      n_cmp++; if (pc !== 32'h14) begin n_err++; $display("FAIL br_pc: got %h want %h", pc, 32'h14); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL br_valid: got %b want 0", if_id_valid); end
      n_cmp++; if (if_id_inst !== NOP) begin n_err++; $display("FAIL br_inst: got %h want %h", if_id_inst, NOP); end
      n_cmp++; if (fetch_cnt !== 32'd3) begin n_err++; $display("FAIL br_cnt: got %0d want 3", fetch_cnt); end
      step();
      n_cmp++; if (if_id_pc4 !== 32'h18) begin n_err++; $display("FAIL br_next_pc4: got %h want %h", if_id_pc4, 32'h18); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL br_next_valid: got %b want 1", if_id_valid); end
      n_cmp++; if (if_id_inst !== 32'hA5000005) begin n_err++; $display("FAIL br_next_inst: got %h want %h", if_id_inst, 32'hA5000005); end
      n_cmp++; if (fetch_cnt !== 32'd4) begin n_err++; $display("FAIL br_next_cnt: got %0d want 4", fetch_cnt); end
   endtask

   task automatic test_branch_stall();
      br_taken = 1'b1; br_target = 32'h20; stall = 1'b1;
      step();
      br_taken = 1'b0; stall = 1'b0;
      n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL brst_pc: got %h want %h", pc, 32'h20); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL brst_valid: got %b want 0", if_id_valid); end
      n_cmp++; if (if_id_inst !== NOP) begin n_err++; $display("FAIL brst_inst: got %h want %h", if_id_inst, NOP); end
      step();
      n_cmp++; if (if_id_inst !== 32'hA5000008) begin n_err++; $display("FAIL brst_next_inst: got %h want %h", if_id_inst, 32'hA5000008); end
      n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL brst_next_pc: got %h want %h", pc, 32'h24); end
      n_cmp++; if (fetch_cnt !== 32'd5) begin n_err++; $display("FAIL brst_next_cnt: got %0d want 5", fetch_cnt); end
   endtask

   task automatic test_wrap();
      br_taken = 1'b1; br_target = 32'hFFFFFFFC;
      step();
      br_taken = 1'b0;
      n_cmp++; if (pc !== 32'hFFFFFFFC) begin n_err++; $display("FAIL wrap_pc0: got %h want %h", pc, 32'hFFFFFFFC); end
      step();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc1: got %h want %h", pc, 32'h0); end
      n_cmp++; if (if_id_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want %h", if_id_pc4, 32'h0); end
      n_cmp++; if (if_id_inst !== 32'hA500003F) begin n_err++; $display("FAIL wrap_inst: got %h want %h", if_id_inst, 32'hA500003F); end
      step();
      n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL wrap_pc2: got %h want %h", pc, 32'h4); end
      n_cmp++; if (if_id_inst !== 32'h3c001000) begin n_err++; $display("FAIL wrap_inst2: got %h want %h", if_id_inst, 32'h3c001000); end
      n_cmp++; if (fetch_cnt !== 32'd7) begin n_err++; $display("FAIL wrap_cnt: got %0d want 7", fetch_cnt); end
   endtask

   task automatic test_misaligned();
      br_taken = 1'b1; br_target = 32'h22;
      step();
      n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %b want 1", fault); end
      n_cmp++; if (fault_pc !== 32'h22) begin n_err++; $display("FAIL mis_fault_pc: got %h want %h", fault_pc, 32'h22); end
      n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL mis_pc: got %h want %h", pc, 32'h4); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL mis_valid: got %b want 0", if_id_valid); end
      n_cmp++; if (if_id_inst !== NOP) begin n_err++; $display("FAIL mis_inst: got %h want %h", if_id_inst, NOP); end
      br_target = 32'h40;
      step();
      br_taken = 1'b0;
      step();
      n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL flt_pc: got %h want %h", pc, 32'h4); end
      n_cmp++; if (fetch_cnt !== 32'd7) begin n_err++; $display("FAIL flt_cnt: got %0d want 7", fetch_cnt); end
      n_cmp++; if (fault_pc !== 32'h22) begin n_err++; $display("FAIL flt_fault_pc: got %h want %h", fault_pc, 32'h22); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL flt_valid: got %b want 0", if_id_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL arst_fault: got %b want 0", fault); end
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL arst_pc: got %h want %h", pc, 32'h0); end
      n_cmp++; if (fault_pc !== 32'h0) begin n_err++; $display("FAIL arst_fault_pc: got %h want 0", fault_pc); end
      n_cmp++; if (fetch_cnt !== 32'd0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", fetch_cnt); end
      step();
      rst_n = 1'b1;
      step();
      n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL post_pc: got %h want %h", pc, 32'h4); end
      n_cmp++; if (if_id_inst !== 32'h3c001000) begin n_err++; $display("FAIL post_inst: got %h want %h", if_id_inst, 32'h3c001000); end
      n_cmp++; if (fetch_cnt !== 32'd1) begin n_err++; $display("FAIL post_cnt: got %0d want 1", fetch_cnt); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
      rom[0] = 32'h3c001000;
      rom[1] = 32'h14003c01;
      rom[2] = 32'h14005002;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_branch_stall();
      test_wrap();
      test_misaligned();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
